unified_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Arbitrates between them, sequences each memory transaction through a registered request/ready handshake, and returns data with a one-cycle acknowledge.
- Also drives the IF stall.
- Placement: between the pipeline and the memory.
  - Replaces separate instruction/data ports.
  - PC / IF-ID write enables are ANDed with `~i_stall` outside this block.

---
 rtl/unified_mem_arbiter_if.sv | 40 ++++
 rtl/unified_mem_arbiter.sv | 92 +++++++++
 tb/tb_unified_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - fetch, data and memory-side signals of the unified memory arbiter
interface unified_mem_arbiter_if #(
   parameter int AW = 10
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [31:0]   i_rdata;
   logic          i_ack;
   logic          i_stall;
   logic          d_req;
   logic          d_we;
   logic [3:0]    d_be;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata;
   logic          d_ack;
   logic          m_req;
   logic          m_we;
   logic [3:0]    m_be;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [31:0]   m_rdata;
   logic          m_ready;
   logic          owner;
   logic          busy;

   // Arbiter side: takes pipeline requests and memory responses.
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ready,
      output i_rdata, i_ack, i_stall, d_rdata, d_ack,
      output m_req, m_we, m_be, m_addr, m_wdata, owner, busy
   );

   // Environment side: pipeline requesters plus the memory itself.
   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ready,
      input  i_rdata, i_ack, i_stall, d_rdata, d_ack,
      input  m_req, m_we, m_be, m_addr, m_wdata, owner, busy
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/MEM arbiter for one single-port unified memory
// Data has priority; fetch is forced through after STARVE_MAX data grants with fetch pending.
module unified_mem_arbiter #(
   parameter int AW         = 10,
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   unified_mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [SW-1:0] starve_cnt;
   logic          starved;
   logic          fetch_win;

   assign starved   = (starve_cnt == SW'(STARVE_MAX));
   assign fetch_win = bus.i_req & (~bus.d_req | starved);

   assign bus.busy    = (state != IDLE);
   assign bus.i_stall = bus.i_req & ~bus.i_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         bus.m_req   <= 1'b0;
         bus.m_we    <= 1'b0;
         bus.m_be    <= 4'h0;
         bus.m_addr  <= '0;
         bus.m_wdata <= 32'h0;
         bus.owner   <= 1'b0;
         bus.i_ack   <= 1'b0;
         bus.d_ack   <= 1'b0;
         bus.i_rdata <= 32'h0;
         bus.d_rdata <= 32'h0;
      end else begin
         bus.i_ack <= 1'b0;
         bus.d_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_req || bus.d_req) begin
                  state     <= WAIT;
                  bus.m_req <= 1'b1;
                  if (fetch_win) begin
                     bus.owner   <= 1'b0;
                     bus.m_we    <= 1'b0;
                     bus.m_be    <= 4'hF;
                     bus.m_addr  <= bus.i_addr;
                     bus.m_wdata <= 32'h0;
                     starve_cnt  <= '0;
                  end else begin
                     bus.owner   <= 1'b1;
                     bus.m_we    <= bus.d_we;
                     bus.m_be    <= bus.d_be;
                     bus.m_addr  <= bus.d_addr;
                     bus.m_wdata <= bus.d_wdata;
                     if (bus.i_req && !starved)
                        starve_cnt <= starve_cnt + SW'(1);
                  end
               end
            end
            WAIT: begin
               if (bus.m_ready) begin
                  state     <= DONE;
                  bus.m_req <= 1'b0;
                  bus.i_ack <= ~bus.owner;
                  bus.d_ack <= bus.owner;
                  // Stores leave both read-data holding registers untouched.
                  if (!bus.m_we) begin
                     if (bus.owner)
                        bus.d_rdata <= bus.m_rdata;
                     else
                        bus.i_rdata <= bus.m_rdata;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   wait_states;
   int   wcnt;
   logic [31:0] rdata_val;

   unified_mem_arbiter_if #(.AW(10)) bus ();

   unified_mem_arbiter #(.AW(10), .STARVE_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: m_ready after wait_states extra cycles of m_req.
   always @(posedge clk) begin
      if (!bus.m_req || bus.m_ready)
         wcnt <= 0;
      else
         wcnt <= wcnt + 1;
   end
   assign bus.m_ready = bus.m_req && (wcnt == wait_states);
   assign bus.m_rdata = rdata_val;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.i_req = 1'b1;
      tick();
      total++; if (bus.m_req !== 1'b0) begin bad++; $display("FAIL rst_m_req got=%b exp=0", bus.m_req); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      total++; if ({bus.i_ack, bus.d_ack, bus.owner, bus.m_we} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {bus.i_ack, bus.d_ack, bus.owner, bus.m_we}); end
      total++; if ({bus.m_be, bus.m_addr, bus.m_wdata} !== 46'h0) begin bad++; $display("FAIL rst_mbus got=%h exp=0", {bus.m_be, bus.m_addr, bus.m_wdata}); end
      total++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {bus.i_rdata, bus.d_rdata}); end
      total++; if (bus.i_stall !== 1'b1) begin bad++; $display("FAIL rst_stall_hi got=%b exp=1", bus.i_stall); end
      bus.i_req = 1'b0;
      #1;
      total++; if (bus.i_stall !== 1'b0) begin bad++; $display("FAIL rst_stall_lo got=%b exp=0", bus.i_stall); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch_zero_wait;
      wait_states = 0;
      rdata_val = 32'h2001_0005;
      bus.i_req = 1'b1;
      bus.i_addr = 10'h004;
      #1;
      total++; if (bus.i_stall !== 1'b1) begin bad++; $display("FAIL fz_stall_t got=%b exp=1", bus.i_stall); end
      tick();
      total++; if (bus.m_req !== 1'b1) begin bad++; $display("FAIL fz_m_req got=%b exp=1", bus.m_req); end
      total++; if ({bus.m_we, bus.m_be, bus.m_addr} !== {1'b0, 4'hF, 10'h004}) begin bad++; $display("FAIL fz_mbus got=%h exp=%h", {bus.m_we, bus.m_be, bus.m_addr}, {1'b0, 4'hF, 10'h004}); end
      total++; if ({bus.owner, bus.busy, bus.i_stall} !== 3'b011) begin bad++; $display("FAIL fz_owner_busy got=%b exp=011", {bus.owner, bus.busy, bus.i_stall}); end
      tick();
      total++; if (bus.i_ack !== 1'b1) begin bad++; $display("FAIL fz_i_ack got=%b exp=1", bus.i_ack); end
      total++; if (bus.i_rdata !== 32'h2001_0005) begin bad++; $display("FAIL fz_i_rdata got=%h exp=20010005", bus.i_rdata); end
      total++; if (bus.i_stall !== 1'b0) begin bad++; $display("FAIL fz_stall_ack got=%b exp=0", bus.i_stall); end
      total++; if (bus.m_req !== 1'b0) begin bad++; $display("FAIL fz_m_req_done got=%b exp=0", bus.m_req); end
      bus.i_req = 1'b0;
      tick();
      total++; if ({bus.busy, bus.i_ack} !== 2'b00) begin bad++; $display("FAIL fz_idle got=%b exp=00", {bus.busy, bus.i_ack}); end
   endtask

   task automatic test_store_wait2;
      wait_states = 2;
      rdata_val = 32'h1234_5678;
      bus.d_req = 1'b1;
      bus.d_we = 1'b1;
      bus.d_be = 4'b0011;
      bus.d_addr = 10'h010;
      bus.d_wdata = 32'hDEAD_BEEF;
      for (int c = 1; c <= 3; c++) begin
         tick();
         total++; if ({bus.m_req, bus.m_we, bus.m_be, bus.owner} !== 7'b1_1_0011_1) begin bad++; $display("FAIL st_hold%0d got=%b exp=1100111", c, {bus.m_req, bus.m_we, bus.m_be, bus.owner}); end
         total++; if ({bus.m_addr, bus.m_wdata} !== {10'h010, 32'hDEAD_BEEF}) begin bad++; $display("FAIL st_addr%0d got=%h exp=%h", c, {bus.m_addr, bus.m_wdata}, {10'h010, 32'hDEAD_BEEF}); end
         total++; if (bus.d_ack !== 1'b0) begin bad++; $display("FAIL st_early_ack%0d got=%b exp=0", c, bus.d_ack); end
      end
      tick();
      total++; if (bus.d_ack !== 1'b1) begin bad++; $display("FAIL st_d_ack got=%b exp=1", bus.d_ack); end
      total++; if (bus.d_rdata !== 32'h0) begin bad++; $display("FAIL st_d_rdata got=%h exp=0", bus.d_rdata); end
      bus.d_req = 1'b0;
      bus.d_we = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous;
      wait_states = 0;
      rdata_val = 32'hAAAA_0001;
      bus.i_req = 1'b1;
      bus.i_addr = 10'h008;
      bus.d_req = 1'b1;
      bus.d_we = 1'b0;
      bus.d_be = 4'hF;
      bus.d_addr = 10'h020;
      tick();
      total++; if ({bus.owner, bus.m_addr, bus.m_we} !== {1'b1, 10'h020, 1'b0}) begin bad++; $display("FAIL sim_dgrant got=%h exp=%h", {bus.owner, bus.m_addr, bus.m_we}, {1'b1, 10'h020, 1'b0}); end
      tick();
      total++; if ({bus.d_ack, bus.i_ack, bus.i_stall} !== 3'b101) begin bad++; $display("FAIL sim_d_ack got=%b exp=101", {bus.d_ack, bus.i_ack, bus.i_stall}); end
      total++; if (bus.d_rdata !== 32'hAAAA_0001) begin bad++; $display("FAIL sim_d_rdata got=%h exp=aaaa0001", bus.d_rdata); end
      bus.d_req = 1'b0;
      rdata_val = 32'hBBBB_0002;
      tick();
      total++; if ({bus.busy, bus.m_req} !== 2'b00) begin bad++; $display("FAIL sim_idle got=%b exp=00", {bus.busy, bus.m_req}); end
      tick();
      total++; if ({bus.m_req, bus.owner, bus.m_addr} !== {1'b1, 1'b0, 10'h008}) begin bad++; $display("FAIL sim_igrant got=%h exp=%h", {bus.m_req, bus.owner, bus.m_addr}, {1'b1, 1'b0, 10'h008}); end
      tick();
      total++; if (bus.i_ack !== 1'b1) begin bad++; $display("FAIL sim_i_ack got=%b exp=1", bus.i_ack); end
      total++; if (bus.i_rdata !== 32'hBBBB_0002) begin bad++; $display("FAIL sim_i_rdata got=%h exp=bbbb0002", bus.i_rdata); end
      total++; if (bus.d_rdata !== 32'hAAAA_0001) begin bad++; $display("FAIL sim_d_keep got=%h exp=aaaa0001", bus.d_rdata); end
      bus.i_req = 1'b0;
      tick();
   endtask

   task automatic test_starvation;
      int  dacks;
      bit  got_i;
      wait_states = 1;
      rdata_val = 32'h5555_0006;
      dacks = 0;
      got_i = 1'b0;
      bus.i_req = 1'b1;
      bus.i_addr = 10'h00C;
      bus.d_req = 1'b1;
      bus.d_we = 1'b0;
      bus.d_addr = 10'h040;
      for (int c = 0; c < 60 && !got_i; c++) begin
         tick();
         if (bus.d_ack) dacks++;
         if (bus.i_ack) got_i = 1'b1;
      end
      total++; if (got_i !== 1'b1) begin bad++; $display("FAIL stv_fetch_timeout got=%b exp=1", got_i); end
      total++; if (dacks != 4) begin bad++; $display("FAIL stv_dgrants got=%0d exp=4", dacks); end
      total++; if (bus.i_rdata !== 32'h5555_0006) begin bad++; $display("FAIL stv_i_rdata got=%h exp=55550006", bus.i_rdata); end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
      total++; if (dut.starve_cnt !== 3'd0) begin bad++; $display("FAIL stv_cnt_clear got=%0d exp=0", dut.starve_cnt); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stv_idle got=%b exp=0", bus.busy); end
   endtask

   task automatic test_reset_in_wait;
      bit acked;
      wait_states = 5;
      acked = 1'b0;
      bus.i_req = 1'b1;
      bus.i_addr = 10'h030;
      tick();
      tick();
      total++; if (bus.m_req !== 1'b1) begin bad++; $display("FAIL rw_m_req_pre got=%b exp=1", bus.m_req); end
      rst = 1'b1;
      #1;
      total++; if ({bus.m_req, bus.busy, bus.i_ack} !== 3'b000) begin bad++; $display("FAIL rw_async got=%b exp=000", {bus.m_req, bus.busy, bus.i_ack}); end
      total++; if (bus.i_stall !== 1'b1) begin bad++; $display("FAIL rw_stall got=%b exp=1", bus.i_stall); end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.i_ack || bus.d_ack) acked = 1'b1;
      end
      total++; if (acked !== 1'b0) begin bad++; $display("FAIL rw_no_ack got=%b exp=0", acked); end
      wait_states = 0;
      rdata_val = 32'hCAFE_0003;
      rst = 1'b0;
      tick();
      total++; if ({bus.m_req, bus.m_addr} !== {1'b1, 10'h030}) begin bad++; $display("FAIL rw_regrant got=%h exp=%h", {bus.m_req, bus.m_addr}, {1'b1, 10'h030}); end
      tick();
      total++; if ({bus.i_ack, bus.i_rdata} !== {1'b1, 32'hCAFE_0003}) begin bad++; $display("FAIL rw_ack got=%h exp=%h", {bus.i_ack, bus.i_rdata}, {1'b1, 32'hCAFE_0003}); end
      bus.i_req = 1'b0;
      tick();
   endtask

   task automatic test_hold_after_grant;
      wait_states = 2;
      rdata_val = 32'h0F0F_1234;
      bus.d_req = 1'b1;
      bus.d_we = 1'b0;
      bus.d_be = 4'hF;
      bus.d_addr = 10'h055;
      bus.d_wdata = 32'h0;
      tick();
      bus.d_addr = 10'h2AA;
      bus.d_we = 1'b1;
      bus.d_wdata = 32'h0000_0001;
      for (int c = 0; c < 3; c++) begin
         total++; if ({bus.m_addr, bus.m_we, bus.m_wdata} !== {10'h055, 1'b0, 32'h0}) begin bad++; $display("FAIL hold_mbus%0d got=%h exp=%h", c, {bus.m_addr, bus.m_we, bus.m_wdata}, {10'h055, 1'b0, 32'h0}); end
         tick();
      end
      total++; if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h0F0F_1234}) begin bad++; $display("FAIL hold_ack got=%h exp=%h", {bus.d_ack, bus.d_rdata}, {1'b1, 32'h0F0F_1234}); end
      bus.d_req = 1'b0;
      bus.d_we = 1'b0;
      tick();
   endtask

   initial begin
      total = 0;
      bad = 0;
      wait_states = 0;
      rdata_val = 32'h0;
      rst = 1'b1;
      bus.i_req = 1'b0;
      bus.i_addr = '0;
      bus.d_req = 1'b0;
      bus.d_we = 1'b0;
      bus.d_be = 4'h0;
      bus.d_addr = '0;
      bus.d_wdata = 32'h0;
      test_reset();
      test_fetch_zero_wait();
      test_store_wait2();
      test_simultaneous();
      test_starvation();
      test_reset_in_wait();
      test_hold_after_grant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
